cdb_writeback_arbiter: RTL and testbench
========================================

// Module: cdb_writeback_arbiter
// PURPOSE
//  Producer end of the common data bus (CDB). Collects finished results from
//  the functional units and grants up to CDB_LANES of them per cycle with
//  fair round-robin selection. The granted results are driven as a registered
//  cdb_packet_t. Reservation stations and the ROB snoop that packet to wake
//  operands and mark entries complete. Sits between the FU output stage and
//  the CDB broadcast net.
// PARAMETERS
//  FU_NUM     6            number of functional units requesting writeback
//  CDB_LANES  `CDB_SIZE    CDB lanes per cycle; must equal `CDB_SIZE
// PORTS
//  clk          in   1                    core clock
//  rst          in   1                    asynchronous, active-high reset
//  flush        in   1                    pipeline flush (mispredict/exception)
//  fu_valid     in   FU_NUM               FU i holds a result
//  fu_reorder   in   FU_NUM x ROB idx     destination ROB index per FU
//  fu_value     in   FU_NUM x 32          result value per FU (uint32_t)
//  fu_ready     out  FU_NUM               result of FU i accepted this cycle
//  cdb_packet   out  cdb_packet_t         registered CDB broadcast, CDB_LANES lanes
// BEHAVIOUR
//  - Reset (async, rst=1): every cdb_packet lane has valid=0, reorder=0 and
//    value=0. rr_ptr=0. fu_ready is all 0 while rst is high.
//  - Handshake: valid/ready. A transfer happens when fu_valid[i] & fu_ready[i].
//    An FU with valid=1 and ready=0 holds its reorder/value stable.
//    fu_ready is combinational from fu_valid, rr_ptr and flush only.
//  - Selection: scan FUs starting at rr_ptr, modulo FU_NUM. Grant the first
//    CDB_LANES valid FUs. Lane k gets the k-th grant in scan order.
//  - Latency: 1 cycle. A result granted in cycle N appears on cdb_packet in
//    cycle N+1 and is held there for exactly one cycle.
//  - Unused lanes: valid=0, reorder=0, value=0. No stale data is driven.
//  - rr_ptr update: set to (last granted FU + 1) mod FU_NUM. Unchanged if
//    nothing is granted. Wrap from FU_NUM-1 to 0.
//  - flush=1: fu_ready all 0 that cycle. cdb_packet lanes are all invalid in
//    the next cycle. rr_ptr is unchanged. Results already registered for this
//    cycle are still visible during the flush cycle itself.
//  - Fewer than CDB_LANES requesters: all of them are granted in the same cycle.
//  - More requesters than lanes: the excess keep valid and win within at most
//    ceil(FU_NUM / CDB_LANES) cycles (starvation-free).
//  - Duplicate reorder indices are not checked. Uniqueness is guaranteed upstream.
//  - Reset mid-transfer: the in-flight grant is lost. Bus valids drop
//    immediately, with no clock edge needed.
// STRUCTURE
//  - Shared package (cpu_defs): cdb_packet_t lane struct {valid, reorder, value},
//    the ROB index type, uint32_t and `CDB_SIZE.
//  - One sub-module, rr_pick: given a request vector and a start pointer,
//    returns a one-hot grant plus the next pointer. It is cascaded CDB_LANES
//    times; each stage masks the previous grants and starts from the previous
//    stage's next pointer.
//  - Top level holds rr_ptr and the cdb_packet register, and applies flush gating.
// TESTING
//  1. Hold rst=1 with all fu_valid=1 -> fu_ready=0 and all cdb_packet lanes
//     invalid. Release rst -> first grants go to FU0 and FU1.
//  2. rr_ptr=0; FU0 (rob 5, 0xAAAA0000) and FU3 (rob 9, 0x12345678) valid ->
//     fu_ready=6'b001001. Next cycle lane0={1,5,0xAAAA0000} and
//     lane1={1,9,0x12345678}. rr_ptr=4.
//  3. All 6 FUs valid and held (FU_NUM=6, lanes=2) -> grants {0,1},{2,3},{4,5},
//     then {0,1} again. Each is visible on the CDB one cycle after its grant.
//  4. rr_ptr=2, only FU5 valid -> lane0 carries FU5, lane1 valid=0 with
//     zeroed fields. rr_ptr wraps to 0.
//  5. FU1 and FU2 valid with flush=1 -> fu_ready=0. Next cycle all lanes are
//     invalid and rr_ptr is unchanged. With flush=0 the cycle after, FU1 and
//     FU2 are granted.
//  6. Assert rst between clock edges while a lane is valid -> lane valid goes
//     to 0 before the next posedge. rr_ptr reads 0 after release.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: CDB width, ROB index type and the CDB lane/packet types.
`ifndef CDB_SIZE
`define CDB_SIZE 2
`endif

package cpu_defs;

  localparam int unsigned CDB_SIZE  = `CDB_SIZE;
  localparam int unsigned ROB_IDX_W = 5;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [31:0]          uint32_t;

  typedef struct packed {
    logic     valid;
    rob_idx_t reorder;
    uint32_t  value;
  } cdb_lane_t;

  typedef cdb_lane_t [CDB_SIZE-1:0] cdb_packet_t;

endpackage

// File: rtl/rr_pick.sv
// Single round-robin pick: first requester at or after start (mod n), plus the pointer past it.
module rr_pick #(
  parameter int unsigned N     = 6,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             found,
  output logic [PTR_W-1:0] next_ptr
);

  always_comb begin
    int unsigned pos;
    pos      = 0;
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    next_ptr = start;
    for (int unsigned off = 0; off < N; off++) begin
      pos = (32'(start) + off) % N;
      if (!found && req[PTR_W'(pos)]) begin
        found              = 1'b1;
        idx                = PTR_W'(pos);
        grant[PTR_W'(pos)] = 1'b1;
        next_ptr           = PTR_W'((pos + 1) % N);
      end
    end
  end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// CDB producer: round-robin grants up to CDB_LANES FU results per cycle into a registered packet.
module cdb_writeback_arbiter
  import cpu_defs::*;
#(
  parameter int unsigned FU_NUM    = 6,
  parameter int unsigned CDB_LANES = CDB_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [FU_NUM-1:0] fu_valid,
  input  rob_idx_t          fu_reorder [FU_NUM],
  input  uint32_t           fu_value   [FU_NUM],
  output logic [FU_NUM-1:0] fu_ready,
  output cdb_packet_t       cdb_packet
);

  localparam int unsigned PTR_W = $clog2(FU_NUM);

  logic [PTR_W-1:0]  rr_ptr;
  logic [FU_NUM-1:0] stage_req   [CDB_LANES+1];
  logic [PTR_W-1:0]  stage_ptr   [CDB_LANES+1];
  logic [FU_NUM-1:0] stage_grant [CDB_LANES];
  logic [PTR_W-1:0]  stage_idx   [CDB_LANES];
  logic [CDB_LANES-1:0] stage_found;
  cdb_packet_t       next_pkt;

  // Flush and reset kill every request so nothing is granted and rr_ptr holds.
  assign stage_req[0] = (rst || flush) ? '0 : fu_valid;
  assign stage_ptr[0] = rr_ptr;

  // Cascade: each lane picks from what earlier lanes left, starting past their grant.
  for (genvar k = 0; k < CDB_LANES; k++) begin : g_lane
    rr_pick #(.N(FU_NUM), .PTR_W(PTR_W)) u_pick (
      .req      (stage_req[k]),
      .start    (stage_ptr[k]),
      .grant    (stage_grant[k]),
      .idx      (stage_idx[k]),
      .found    (stage_found[k]),
      .next_ptr (stage_ptr[k+1])
    );

    assign stage_req[k+1] = stage_req[k] & ~stage_grant[k];

    assign next_pkt[k] = stage_found[k]
                       ? cdb_lane_t'({1'b1, fu_reorder[stage_idx[k]], fu_value[stage_idx[k]]})
                       : cdb_lane_t'('0);
  end

  assign fu_ready = stage_req[0] & ~stage_req[CDB_LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      cdb_packet <= '0;
    end else begin
      rr_ptr     <= stage_ptr[CDB_LANES];
      cdb_packet <= next_pkt;
    end
  end

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: directed sequences, a vector table and a randomized model check.
module tb_cdb_writeback_arbiter;
  import cpu_defs::*;

  localparam int unsigned FU_NUM = 6;
  localparam int unsigned LANES  = CDB_SIZE;
  localparam int unsigned IW     = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [FU_NUM-1:0] fu_valid = '0;
  logic [FU_NUM-1:0] fu_ready;
  rob_idx_t          fu_reorder [FU_NUM];
  uint32_t           fu_value   [FU_NUM];
  cdb_packet_t       cdb_packet;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdb_writeback_arbiter #(.FU_NUM(FU_NUM), .CDB_LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fu_valid   (fu_valid),
    .fu_reorder (fu_reorder),
    .fu_value   (fu_value),
    .fu_ready   (fu_ready),
    .cdb_packet (cdb_packet)
  );

  rob_idx_t rob_tab [FU_NUM] = '{5'd5, 5'd2, 5'd7, 5'd9, 5'd11, 5'd13};
  uint32_t  val_tab [FU_NUM] = '{32'hAAAA0000, 32'h11111111, 32'h22222222,
                                 32'h12345678, 32'h44444444, 32'h55555555};

  typedef struct {
    logic [FU_NUM-1:0] valid;
    logic              fl;
    logic [FU_NUM-1:0] ready;
    int                f0;
    int                f1;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic cdb_lane_t lane_of(input int fu);
    cdb_lane_t l;
    l = '0;
    if (fu >= 0) begin
      l.valid   = 1'b1;
      l.reorder = rob_tab[IW'(fu)];
      l.value   = val_tab[IW'(fu)];
    end
    return l;
  endfunction

  task automatic chk_pkt(input string name, input cdb_packet_t exp);
    for (int k = 0; k < LANES; k++)
      chk($sformatf("%s lane%0d", name, k), 64'(cdb_packet[k]), 64'(exp[k]));
  endtask

  // Reference: list valid FUs in scan order from ptr, grant the first LANES of them.
  task automatic model_pick(input logic [FU_NUM-1:0] v, input logic fl, input int ptr,
                            output int gr [LANES], output int nxt);
    int q[$];
    for (int off = 0; off < FU_NUM; off++) begin
      int f;
      f = (ptr + off) % FU_NUM;
      if (!fl && v[IW'(f)]) q.push_back(f);
    end
    nxt = ptr;
    for (int k = 0; k < LANES; k++) begin
      gr[k] = (k < q.size()) ? q[k] : -1;
      if (gr[k] >= 0) nxt = (gr[k] + 1) % FU_NUM;
    end
  endtask

  initial begin
    vec_t        vecs [11];
    cdb_packet_t exp_pkt, prev_pkt;
    logic [FU_NUM-1:0] exp_ready, cur_valid;
    rob_idx_t    cur_rob [FU_NUM];
    uint32_t     cur_val [FU_NUM];
    int          waits   [FU_NUM];
    int          gr      [LANES];
    int          rr_m, nxt;
    logic        fl;

    fu_reorder = rob_tab;
    fu_value   = val_tab;

    // Reset held with every FU requesting.
    fu_valid = '1;
    @(posedge clk); #1;
    chk("reset ready", 64'(fu_ready), 64'(0));
    chk_pkt("reset pkt", '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All FUs held valid: pairs {0,1},{2,3},{4,5},{0,1}.
    for (int c = 0; c < 4; c++) begin
      int b;
      b = 2 * (c % 3);
      #2;
      chk($sformatf("allvalid ready c%0d", c), 64'(fu_ready), 64'(6'b11 << b));
      @(posedge clk); #1;
      exp_pkt[0] = lane_of(b);
      exp_pkt[1] = lane_of(b + 1);
      chk_pkt($sformatf("allvalid pkt c%0d", c), exp_pkt);
    end

    // Reset between edges while lanes are valid; pointer returns to 0.
    #2;
    rst = 1'b1;
    #1;
    chk("midreset lane0 valid", 64'(cdb_packet[0].valid), 64'(0));
    chk("midreset ready", 64'(fu_ready), 64'(0));
    chk_pkt("midreset pkt", '0);
    @(posedge clk); #1;
    rst = 1'b0;
    #2;
    chk("post-reset ready", 64'(fu_ready), 64'(6'b000011));
    @(posedge clk); #1;
    exp_pkt[0] = lane_of(0);
    exp_pkt[1] = lane_of(1);
    chk_pkt("post-reset pkt", exp_pkt);

    // Vector table from a fresh reset (rr_ptr = 0).
    fu_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vecs[0]  = '{6'b001001, 1'b0, 6'b001001,  0,  3};
    vecs[1]  = '{6'b111111, 1'b0, 6'b110000,  4,  5};
    vecs[2]  = '{6'b111111, 1'b0, 6'b000011,  0,  1};
    vecs[3]  = '{6'b100000, 1'b0, 6'b100000,  5, -1};
    vecs[4]  = '{6'b000110, 1'b1, 6'b000000, -1, -1};
    vecs[5]  = '{6'b000110, 1'b0, 6'b000110,  1,  2};
    vecs[6]  = '{6'b000111, 1'b0, 6'b000011,  0,  1};
    vecs[7]  = '{6'b000000, 1'b0, 6'b000000, -1, -1};
    vecs[8]  = '{6'b000011, 1'b0, 6'b000011,  0,  1};
    vecs[9]  = '{6'b011100, 1'b0, 6'b001100,  2,  3};
    vecs[10] = '{6'b010001, 1'b0, 6'b010001,  4,  0};
    prev_pkt = '0;
    for (int i = 0; i < 11; i++) begin
      fu_valid = vecs[i].valid;
      flush    = vecs[i].fl;
      #2;
      chk($sformatf("vec%0d ready", i), 64'(fu_ready), 64'(vecs[i].ready));
      chk_pkt($sformatf("vec%0d hold", i), prev_pkt);
      @(posedge clk); #1;
      exp_pkt[0] = lane_of(vecs[i].f0);
      exp_pkt[1] = lane_of(vecs[i].f1);
      chk_pkt($sformatf("vec%0d pkt", i), exp_pkt);
      prev_pkt = exp_pkt;
    end
    flush = 1'b0;

    // Randomized traffic against the reference model, with hold-until-accepted FUs.
    fu_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rr_m      = 0;
    cur_valid = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      waits[i]   = 0;
      cur_rob[i] = '0;
      cur_val[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < FU_NUM; i++) begin
        if (!cur_valid[IW'(i)]) begin
          cur_valid[IW'(i)] = ($urandom_range(0, 99) < 55);
          cur_rob[i] = rob_idx_t'($urandom);
          cur_val[i] = $urandom;
        end
      end
      fl = ($urandom_range(0, 9) == 0);
      fu_valid   = cur_valid;
      fu_reorder = cur_rob;
      fu_value   = cur_val;
      flush      = fl;
      model_pick(cur_valid, fl, rr_m, gr, nxt);
      exp_ready = '0;
      exp_pkt   = '0;
      for (int k = 0; k < LANES; k++) begin
        if (gr[k] >= 0) begin
          exp_ready[IW'(gr[k])] = 1'b1;
          exp_pkt[k].valid   = 1'b1;
          exp_pkt[k].reorder = cur_rob[IW'(gr[k])];
          exp_pkt[k].value   = cur_val[IW'(gr[k])];
        end
      end
      #2;
      chk($sformatf("rand%0d ready", c), 64'(fu_ready), 64'(exp_ready));
      @(posedge clk); #1;
      chk_pkt($sformatf("rand%0d pkt", c), exp_pkt);
      for (int i = 0; i < FU_NUM; i++) begin
        if (cur_valid[IW'(i)] && !fl) waits[i]++;
        if (exp_ready[IW'(i)]) begin
          chk($sformatf("rand%0d starve fu%0d", c, i), 64'(waits[i] <= 3), 64'(1));
          waits[i] = 0;
          cur_valid[IW'(i)] = 1'b0;
        end
      end
      rr_m = nxt;
    end
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
